// File: rtl/usr_pkg.sv
// usr_pkg: shared state encoding and default word width for the serializer and its shift register.
package usr_pkg;
  localparam int USR_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
endpackage

// File: rtl/usr_tx_ctrl.sv
// usr_tx_ctrl: drives a universal shift register's load/hold/shift controls to serialize accepted words.
module usr_tx_ctrl
  import usr_pkg::*;
#(
  parameter int   WIDTH      = USR_WIDTH,
  parameter int   GAP_CYCLES = 1,
  parameter logic FILL_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_lsb_first,
  output logic             in_ready,
  input  logic             stall,
  output logic             load,
  output logic             hold,
  output logic             shift_left,
  output logic             shift_right,
  output logic [WIDTH-1:0] parallel_in,
  output logic             serial_in,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [GW-1:0]    r_gap;
  logic             r_dir;
  logic [WIDTH-1:0] r_data;
  assign parallel_in = r_data;
  assign serial_in   = FILL_BIT;
  // Shift direction is held through stalls so the register's serial output stays on the pending bit.
  always_comb begin
    in_ready    = r_state == IDLE && !res;
    load        = r_state == LOAD;
    shift_left  = r_state == SHIFT && !r_dir;
    shift_right = r_state == SHIFT && r_dir;
    hold        = r_state == SHIFT && stall;
    bit_valid   = r_state == SHIFT && !stall;
    last_bit    = bit_valid && r_cnt == CW'(WIDTH - 1);
    busy        = r_state != IDLE;
    w_next      = r_state == IDLE  ? (in_valid && in_ready ? LOAD : IDLE)
                : r_state == LOAD  ? SHIFT
                : r_state == SHIFT ? (last_bit ? (GAP_CYCLES > 0 ? GAP : IDLE) : SHIFT)
                : (r_gap == GW'(GAP_CYCLES - 1) ? IDLE : GAP);
  end
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_dir   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (in_valid && in_ready) begin
        r_data <= in_data;
        r_dir  <= in_lsb_first;
      end
      r_cnt <= r_state == SHIFT ? (last_bit ? '0 : r_cnt + CW'(bit_valid)) : '0;
      r_gap <= r_state == GAP ? r_gap + GW'(1) : '0;
    end
  end
endmodule

// File: tb/tb_usr_tx_ctrl.sv
// tb_usr_tx_ctrl: two controllers (gap 1 and gap 0) each paired with a shift register model, checked against a word-level model.
module tb_usr_tx_ctrl;
  localparam int W = 8;
  logic       clk = 1'b0, res = 1'b1, in_valid = 1'b0, in_lsb_first = 1'b0, stall = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [1:0] rdy, ld, hd, sl, sr, si, bv, lb, bz;
  logic [7:0] pin [2];
  logic [7:0] q [2];
  int checks = 0, errors = 0, cyc = 0;
  int m_load [2], m_bits [2], m_gap [2];
  logic [7:0] m_word [2];
  logic m_dir [2];
  int load_cyc [2], last_cyc [2], first_last [2], nlast [2], nhold [2], nsl [2], nbv [2];
  int nld [2], nacc [2], acc_cyc [2], rdy_cyc [2], nrdy [2];
  logic [63:0] stream [2];
  logic prev_rdy [2];

  always #10 clk = ~clk;

  usr_tx_ctrl #(.WIDTH(W), .GAP_CYCLES(1), .FILL_BIT(1'b0)) u0 (
    .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data), .in_lsb_first(in_lsb_first),
    .in_ready(rdy[0]), .stall(stall), .load(ld[0]), .hold(hd[0]), .shift_left(sl[0]),
    .shift_right(sr[0]), .parallel_in(pin[0]), .serial_in(si[0]), .bit_valid(bv[0]),
    .last_bit(lb[0]), .busy(bz[0]));
  usr_tx_ctrl #(.WIDTH(W), .GAP_CYCLES(0), .FILL_BIT(1'b0)) u1 (
    .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data), .in_lsb_first(in_lsb_first),
    .in_ready(rdy[1]), .stall(stall), .load(ld[1]), .hold(hd[1]), .shift_left(sl[1]),
    .shift_right(sr[1]), .parallel_in(pin[1]), .serial_in(si[1]), .bit_valid(bv[1]),
    .last_bit(lb[1]), .busy(bz[1]));

  // Universal shift register driven by each controller.
  always @(posedge clk or posedge res)
    for (int k = 0; k < 2; k++)
      if (res) q[k] <= '0;
      else if (ld[k]) q[k] <= pin[k];
      else if (hd[k]) q[k] <= q[k];
      else if (sl[k]) q[k] <= {q[k][6:0], si[k]};
      else if (sr[k]) q[k] <= {si[k], q[k][7:1]};

  task automatic chk(string name, int k, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  task automatic model_reset;
    for (int k = 0; k < 2; k++) begin
      m_load[k] = 0; m_bits[k] = 0; m_gap[k] = 0;
    end
  endtask

  task automatic clear_logs;
    for (int k = 0; k < 2; k++) begin
      load_cyc[k] = -1; last_cyc[k] = -1; first_last[k] = -1; nlast[k] = 0; nhold[k] = 0;
      nsl[k] = 0; nbv[k] = 0; nld[k] = 0; nacc[k] = 0; acc_cyc[k] = -1; rdy_cyc[k] = -1;
      nrdy[k] = 0; stream[k] = '0; prev_rdy[k] = 1'b1;
    end
  endtask

  // Called at a negedge with inputs settled: compare, then advance the model at the next posedge.
  task automatic step;
    logic o;
    logic busy, shifting, ebv;
    #1;
    for (int k = 0; k < 2; k++) begin
      busy     = m_load[k] != 0 || m_bits[k] != 0 || m_gap[k] != 0;
      shifting = m_bits[k] != 0;
      ebv      = shifting && !stall;
      o        = sr[k] ? q[k][0] : q[k][7];
      chk("in_ready", k, rdy[k], !busy && !res);
      chk("busy", k, bz[k], busy);
      chk("load", k, ld[k], m_load[k] != 0);
      chk("hold", k, hd[k], shifting && stall);
      chk("shift_left", k, sl[k], shifting && !m_dir[k]);
      chk("shift_right", k, sr[k], shifting && m_dir[k]);
      chk("bit_valid", k, bv[k], ebv);
      chk("last_bit", k, lb[k], ebv && m_bits[k] == 1);
      chk("serial_in", k, si[k], 1'b0);
      if (shifting)
        chk("serial_out", k, o, m_dir[k] ? m_word[k][W-m_bits[k]] : m_word[k][m_bits[k]-1]);
      if (ld[k]) begin load_cyc[k] = cyc; nld[k]++; end
      if (hd[k]) nhold[k]++;
      if (sl[k]) nsl[k]++;
      if (bv[k]) begin stream[k] = {stream[k][62:0], o}; nbv[k]++; end
      if (lb[k]) begin
        last_cyc[k] = cyc; nlast[k]++;
        if (first_last[k] < 0) first_last[k] = cyc;
      end
      if (rdy[k]) nrdy[k]++;
      if (rdy[k] && !prev_rdy[k] && rdy_cyc[k] < 0) rdy_cyc[k] = cyc;
      prev_rdy[k] = rdy[k];
      if (in_valid && rdy[k]) begin acc_cyc[k] = cyc; nacc[k]++; end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (res) begin
        m_load[k] = 0; m_bits[k] = 0; m_gap[k] = 0;
      end else if (m_load[k] != 0) begin
        m_load[k] = 0; m_bits[k] = W;
      end else if (m_bits[k] != 0) begin
        if (!stall) begin
          m_bits[k]--;
          if (m_bits[k] == 0) m_gap[k] = (k == 0) ? 1 : 0;
        end
      end else if (m_gap[k] != 0) m_gap[k]--;
      else if (in_valid) begin
        m_load[k] = 1; m_word[k] = in_data; m_dir[k] = in_lsb_first;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int t, n;
    model_reset();
    clear_logs();
    @(negedge clk);
    #1;
    chk("rst_ready", 0, rdy[0], 1'b0);
    step(); step();
    res = 1'b0;
    step();
    chk("post_rst_ready", 0, rdy[0], 1'b1);

    // MSB-first A5
    clear_logs();
    in_valid = 1'b1; in_data = 8'hA5; in_lsb_first = 1'b0;
    step();
    in_valid = 1'b0; in_data = 8'hFF;
    repeat (12) step();
    t = acc_cyc[0];
    chk("t1_load_cyc", 0, load_cyc[0], t + 1);
    chk("t1_bits", 0, stream[0][7:0], 8'hA5);
    chk("t1_nbits", 0, nbv[0], 8);
    chk("t1_last_cyc", 0, last_cyc[0], t + 9);
    chk("t1_nlast", 0, nlast[0], 1);
    chk("t1_ready_cyc", 0, rdy_cyc[0], t + 11);
    chk("t1_ready_cyc", 1, rdy_cyc[1], t + 10);

    // LSB-first 81 then 3C back-to-back
    clear_logs();
    in_valid = 1'b1; in_data = 8'h81; in_lsb_first = 1'b1;
    n = 0;
    while (nacc[0] < 1 && n < 5) begin step(); n++; end
    in_data = 8'h3C;
    while (nacc[0] < 2 && n < 40) begin step(); n++; end
    in_valid = 1'b0;
    repeat (14) step();
    chk("t2_accepts", 0, nacc[0], 2);
    chk("t2_bits", 0, stream[0][15:0], 16'h813C);
    chk("t2_bits", 1, stream[1][15:0], 16'h813C);
    chk("t2_no_shift_left", 0, nsl[0], 0);
    chk("t2_nlast", 0, nlast[0], 2);
    chk("t2_gap", 0, load_cyc[0] - first_last[0], 3);
    chk("t2_gap", 1, load_cyc[1] - first_last[1], 2);

    // stall 3 cycles on bit 2 of F0
    clear_logs();
    in_valid = 1'b1; in_data = 8'hF0; in_lsb_first = 1'b0;
    step();
    in_valid = 1'b0;
    t = acc_cyc[0];
    repeat (3) step();
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    repeat (10) step();
    chk("t3_bits", 0, stream[0][7:0], 8'hF0);
    chk("t3_nhold", 0, nhold[0], 3);
    chk("t3_nbits", 0, nbv[0], 8);
    chk("t3_last_cyc", 0, last_cyc[0], t + 12);
    chk("t3_last_cyc", 1, last_cyc[1], t + 12);

    // async reset after 4 bits, then 5A
    clear_logs();
    in_valid = 1'b1; in_data = 8'hC3; in_lsb_first = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #3 res = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++)
      chk("t4_async_clear", k, {ld[k], hd[k], sl[k], sr[k], bv[k], lb[k], bz[k], rdy[k]}, 8'h00);
    chk("t4_bits_before", 0, nbv[0], 4);
    chk("t4_no_last", 0, nlast[0], 0);
    step(); step();
    res = 1'b0;
    step();
    chk("t4_ready", 0, rdy[0], 1'b1);
    clear_logs();
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    repeat (11) step();
    chk("t4_bits", 0, stream[0][7:0], 8'h5A);
    chk("t4_bits", 1, stream[1][7:0], 8'h5A);
    chk("t4_nlast", 0, nlast[0], 1);

    // back-to-back with stall during LOAD and GAP
    clear_logs();
    in_valid = 1'b1; in_data = 8'h96; in_lsb_first = 1'b0;
    step();
    in_data = 8'h69;
    stall = 1'b1;
    step();
    stall = 1'b0;
    n = 0;
    while (nacc[0] < 2 && n < 40) begin
      stall = first_last[0] >= 0 && cyc == first_last[0] + 1;
      step(); n++;
    end
    stall = 1'b0; in_valid = 1'b0;
    repeat (12) step();
    chk("t5_bits", 0, stream[0][15:0], 16'h9669);
    chk("t5_bits", 1, stream[1][15:0], 16'h9669);
    chk("t5_nhold", 0, nhold[0], 0);
    chk("t5_nhold", 1, nhold[1], 0);
    chk("t5_reload", 0, load_cyc[0] - first_last[0], 3);
    chk("t5_reload", 1, load_cyc[1] - first_last[1], 2);
    chk("t5_last2", 0, last_cyc[0] - first_last[0], 11);
    chk("t5_last2", 1, last_cyc[1] - first_last[1], 10);

    // idle with stall toggling
    clear_logs();
    for (int i = 0; i < 20; i++) begin
      stall = i[0];
      step();
    end
    stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("t6_no_load", k, nld[k], 0);
      chk("t6_no_hold", k, nhold[k], 0);
      chk("t6_no_bits", k, nbv[k], 0);
      chk("t6_ready", k, nrdy[k], 20);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
